// File: rtl/regfile_core.sv
`default_nettype none
// ============================================================================
// Module   : regfile_core
// Purpose  : 31 x WIDTH register file, one-hot write strobe, two combinational
//            read ports with optional write-to-read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_core #(
  parameter int WIDTH  = 32,
  parameter int BYPASS = 1
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic [31:0]      write_onehot,
  input  logic [WIDTH-1:0] data_writeReg,
  input  logic [4:0]       ctrl_readRegA,
  input  logic [4:0]       ctrl_readRegB,
  output logic [WIDTH-1:0] data_readRegA,
  output logic [WIDTH-1:0] data_readRegB,
  output logic             err_multi,
  output logic             err_sticky
);

  logic [WIDTH-1:0] r_regs [1:31];
  logic [WIDTH-1:0] w_regView [0:31];
  logic [5:0]       w_popCount;
  logic             w_oneHot;
  logic             w_multiHot;
  logic             w_writeEn;
  logic             w_fwdA;
  logic             w_fwdB;
  logic             r_errMulti;
  logic             r_errSticky;

  // Population count, so a multi-hot strobe is never silently priority-resolved.
  assign w_popCount = 6'($countones(write_onehot));
  assign w_oneHot   = (w_popCount == 6'd1);
  assign w_multiHot = (w_popCount > 6'd1);
  assign w_writeEn  = ~ctrl_reset & w_oneHot & ~write_onehot[0];

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 1; i < 32; i++) r_regs[i] <= '0;
      r_errMulti  <= 1'b0;
      r_errSticky <= 1'b0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (w_writeEn && write_onehot[i]) r_regs[i] <= data_writeReg;
      end
      r_errMulti  <= w_multiHot;
      r_errSticky <= r_errSticky | w_multiHot;
    end
  end

  assign w_regView[0] = '0;
  generate
    for (genvar g = 1; g < 32; g++) begin : g_regView
      assign w_regView[g] = r_regs[g];
    end

    // w_writeEn already excludes reset, multi-hot and bit 0, so a single bit test suffices.
    if (BYPASS != 0) begin : g_bypass
      assign w_fwdA = w_writeEn & write_onehot[ctrl_readRegA];
      assign w_fwdB = w_writeEn & write_onehot[ctrl_readRegB];
    end else begin : g_noBypass
      assign w_fwdA = 1'b0;
      assign w_fwdB = 1'b0;
    end
  endgenerate

  assign data_readRegA = w_fwdA ? data_writeReg : w_regView[ctrl_readRegA];
  assign data_readRegB = w_fwdB ? data_writeReg : w_regView[ctrl_readRegB];
  assign err_multi     = r_errMulti;
  assign err_sticky    = r_errSticky;

endmodule
`default_nettype wire

// File: doc/regfile_core.md
REGFILE_CORE -- requirements
Module: regfile_core

Interface
REQ-001 Parameter: WIDTH, 32, data width of every register and data port.
REQ-002 Parameter: BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports; when 0 there is no forwarding.
REQ-003 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port: ctrl_reset  input  1  reset, synchronous and active-high.
REQ-005 Port: write_onehot  input  32  one-hot write strobe produced by the upstream write-port decoder; bit i selects register i.
REQ-006 Port: data_writeReg  input  WIDTH  write data.
REQ-007 Port: ctrl_readRegA  input  5  read port A register index.
REQ-008 Port: ctrl_readRegB  input  5  read port B register index.
REQ-009 Port: data_readRegA  output  WIDTH  read port A data.
REQ-010 Port: data_readRegB  output  WIDTH  read port B data.
REQ-011 Port: err_multi  output  1  registered one-cycle pulse: more than one write_onehot bit was set on the previous edge.
REQ-012 Port: err_sticky  output  1  registered flag: a multi-hot strobe has occurred since the last reset.

Function
REQ-013 Storage: 31 registers r1..r31, each WIDTH bits; r0 has no storage and always reads 0.
REQ-014 Write: on a rising edge with ctrl_reset=0 and write_onehot having exactly one bit i set, i!=0 -> r[i] <= data_writeReg.
REQ-015 write_onehot bit 0 alone -> no state change, no error.
REQ-016 write_onehot == 0 -> no state change, no error.
REQ-017 write_onehot with two or more bits set -> no register written; err_multi=1 for exactly the next cycle; err_sticky<=1.
REQ-018 err_multi deasserts on the following edge unless another multi-hot strobe occurs; back-to-back multi-hot strobes hold it high.
REQ-019 err_sticky holds 1 until ctrl_reset.
REQ-020 Reads: combinational, zero latency; data_readRegX = r[ctrl_readRegX], or 0 when the index is 0.
REQ-021 Bypass (BYPASS=1): if ctrl_reset=0, write_onehot is exactly one-hot at bit k!=0, and ctrl_readRegX==k -> data_readRegX = data_writeReg in the same cycle.
REQ-022 Bypass does not apply when the strobe is multi-hot, when k=0, or while ctrl_reset=1.
REQ-023 BYPASS=0: reads return the pre-edge stored value; the new value is visible from the cycle after the edge.
REQ-024 Ports A and B are independent; equal indices return identical data, including the bypassed value.
REQ-025 The one-hot check is a population-count test over all 32 bits, not a priority encode.

Reset
REQ-026 ctrl_reset=1 at a rising edge -> r1..r31 <= 0, err_multi <= 0, err_sticky <= 0.
REQ-027 Reset has priority over any same-edge write or multi-hot strobe; that write is discarded and no error is recorded.
REQ-028 Reads during a reset cycle return stored (pre-reset) contents with no bypass; from the cycle after reset all reads return 0.
REQ-029 Reset asserted mid-sequence (between two writes) clears all state; later writes behave as after a fresh reset.

Verification
REQ-030 Reset, write_onehot=0x0000_0020, data=0xDEAD_BEEF, then read A=5 and B=5 -> both 0xDEAD_BEEF; err_multi=0.
REQ-031 write_onehot=0x0000_0001, data=0xFFFF_FFFF, then read A=0 -> 0; no error flags.
REQ-032 BYPASS=1: r7=0x1111_1111; same cycle write_onehot=0x80, data=0x2222_2222, read A=7 -> 0x2222_2222 before the edge. BYPASS=0: same stimulus -> 0x1111_1111 before the edge, 0x2222_2222 after.
REQ-033 r3=0xA, r4=0xB; write_onehot=0x18, data=0xC -> r3=0xA, r4=0xB; err_multi=1 for one cycle; err_sticky stays 1; no bypass.
REQ-034 ctrl_reset=1 together with write_onehot=0x0000_0400, data=0x5 -> the cycle after shows read A=10 -> 0, err_sticky=0.
REQ-035 Write all 31 registers with value = index, then read every pair (i, 31-i) -> i and 31-i, with r0 returning 0.
